// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: XLEN, bubble instruction and FSM encoding.
// The FAULT state only exists when IMEM_FETCH_FAULT_EN is defined.
package imem_fetch_ctrl_pkg;

    localparam int          XLEN            = 32;
    localparam logic [31:0] NOP_INS_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
`ifdef IMEM_FETCH_FAULT_EN
        ,ST_FAULT = 2'd3
`endif
    } fetch_state_t;

endpackage

// File: rtl/imem_fetch_ctrl_if_id_reg.sv
// IF/ID pipeline register: captures pc/ins/valid, holds on stall, flushes to a NOP bubble.
// Flush has priority over hold so a redirect can squash a stalled entry.
module if_id_reg
    import imem_fetch_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INS = NOP_INS_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold,
    input  logic            flush,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_ins,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_ins,
    output logic            if_valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_pc    <= '0;
            if_ins   <= NOP_INS;
            if_valid <= 1'b0;
        end else if (flush) begin
            if_pc    <= load_pc;
            if_ins   <= NOP_INS;
            if_valid <= 1'b0;
        end else if (!hold) begin
            if_pc    <= load_pc;
            if_ins   <= load_ins;
            if_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch-stage sequencer: PC register, BOOT/RUN/HALT FSM, issue counter and IF/ID capture.
// Define IMEM_FETCH_FAULT_EN to enable the misaligned/out-of-range fetch fault and sticky FAULT state.
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              IMEM_ROW = 256,
    parameter logic [XLEN-1:0] NOP_INS  = NOP_INS_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_pc,
    input  logic [XLEN-1:0] imem_ins,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt_req,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_ins,
    output logic            if_valid,
    output logic [XLEN-1:0] fetch_cnt,
    output logic            fault,
    output logic [XLEN-1:0] fault_pc
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] cnt_d;
    logic [XLEN-1:0] id_pc;
    logic            id_hold, id_flush;
`ifdef IMEM_FETCH_FAULT_EN
    logic            bad_pc;
    logic            fault_set;

    assign bad_pc = (pc_q[1:0] != 2'b00) || (pc_q[31:2] >= 30'(IMEM_ROW));
`endif

    assign imem_pc = pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            fetch_cnt <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            fetch_cnt <= cnt_d;
        end
    end

    // Priority inside RUN: redirect > stall > (fault check) > halt_req > issue.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = fetch_cnt;
        id_hold  = 1'b1;
        id_flush = 1'b0;
        id_pc    = pc_q;
`ifdef IMEM_FETCH_FAULT_EN
        fault_set = 1'b0;
`endif
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                if (redirect) begin
                    pc_d = redirect_pc;
                end
            end
            ST_RUN: begin
                if (redirect) begin
                    pc_d     = redirect_pc;
                    id_flush = 1'b1;
                    id_pc    = redirect_pc;
                end else if (stall) begin
                    if (halt_req) begin
                        state_d = ST_HALT;
                    end
`ifdef IMEM_FETCH_FAULT_EN
                end else if (bad_pc) begin
                    id_flush  = 1'b1;
                    fault_set = 1'b1;
                    state_d   = ST_FAULT;
`endif
                end else if (halt_req) begin
                    id_flush = 1'b1;
                    state_d  = ST_HALT;
                end else begin
                    id_hold = 1'b0;
                    pc_d    = pc_q + 32'd4;
                    cnt_d   = fetch_cnt + 32'd1;
                end
            end
            ST_HALT: begin
                if (redirect) begin
                    pc_d     = redirect_pc;
                    id_flush = 1'b1;
                    id_pc    = redirect_pc;
                end else if (!stall) begin
                    id_flush = 1'b1;
                end
                if (!halt_req) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
            end
        endcase
    end

`ifdef IMEM_FETCH_FAULT_EN
    // Fault flag and address are sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault    <= 1'b0;
            fault_pc <= '0;
        end else if (fault_set) begin
            fault    <= 1'b1;
            fault_pc <= pc_q;
        end
    end
`else
    assign fault    = 1'b0;
    assign fault_pc = '0;
`endif

    if_id_reg #(
        .NOP_INS (NOP_INS)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .hold     (id_hold),
        .flush    (id_flush),
        .load_pc  (id_pc),
        .load_ins (imem_ins),
        .if_pc    (if_pc),
        .if_ins   (if_ins),
        .if_valid (if_valid)
    );

endmodule
